mc_sequencer: RTL and testbench

- Microcode sequencer directly upstream of mc_decoder.
- Runs the machine-cycle phase counter (S1..S6) and selects the microcode ROM address: opcode entry, continuation, interrupt entry or reset entry.
- Captures the ROM word and drives o_mc_b and the phase buses into mc_decoder's i_mc_b, i_t_p_d and i_t_p_q.
- Handles multi-cycle chaining via microcode bit 53, holds/stalls, and interrupt insertion at instruction boundaries.

---
 rtl/mc_sequencer.sv | 103 ++++++++++
 tb/tb_mc_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Microcode sequencer: runs the S1..S6 phase counter, picks the next microcode
// ROM address (reset, interrupt, opcode, continuation or NOP entry) and captures the ROM word.
module mc_sequencer #(
   parameter int                         MCODE_WIDTH   = 54,
   parameter int                         MC_ADDR_WIDTH = 9,
   parameter logic [MC_ADDR_WIDTH-1:0]   RESET_ENTRY   = 9'h1FE,
   parameter logic [MC_ADDR_WIDTH-1:0]   INT_ENTRY     = 9'h1FC
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 i_hold,
   input  logic [7:0]                           i_opcode,
   input  logic                                 i_opcode_vld,
   input  logic                                 i_int_req,
   input  logic [MCODE_WIDTH+MC_ADDR_WIDTH-1:0] i_mc_rom_data,
   output logic [MC_ADDR_WIDTH-1:0]             o_mc_addr,
   output logic [MCODE_WIDTH-1:0]               o_mc_b,
   output logic [3:0]                           o_t_p_d,
   output logic [3:0]                           o_t_p_q,
   output logic                                 o_int_ack,
   output logic                                 o_instr_done
);

   logic [3:0]               t_p_q;
   logic [3:0]               t_p_d;
   logic [MC_ADDR_WIDTH-1:0] mc_addr;
   logic [MCODE_WIDTH-1:0]   mc_b;
   logic                     first_flag;
   logic                     int_ack_r;
   logic                     instr_done_r;

   logic                     addr_edge;
   logic                     capture_edge;
   logic                     continuation;
   logic [MC_ADDR_WIDTH-1:0] next_addr;
   logic                     take_int;
   logic                     boundary_done;

   // Illegal phase codes (0, 7..15) fall back to S1 just like a normal S6 wrap.
   always_comb begin
      t_p_d = t_p_q;
      if (!i_hold) begin
         if (t_p_q == 4'd0 || t_p_q >= 4'd6) t_p_d = 4'd1;
         else                                 t_p_d = t_p_q + 4'd1;
      end
   end

   assign addr_edge    = (t_p_q == 4'd5) && !i_hold;
   assign capture_edge = (t_p_q == 4'd6) && !i_hold;
   assign continuation = mc_b[MCODE_WIDTH-1];

   always_comb begin
      next_addr     = '0;
      take_int      = 1'b0;
      boundary_done = 1'b0;
      if (continuation) begin
         next_addr = i_mc_rom_data[MCODE_WIDTH +: MC_ADDR_WIDTH];
      end else if (first_flag) begin
         next_addr = RESET_ENTRY;
      end else if (i_int_req) begin
         next_addr     = INT_ENTRY;
         take_int      = 1'b1;
         boundary_done = 1'b1;
      end else if (i_opcode_vld) begin
         next_addr     = MC_ADDR_WIDTH'({i_opcode, 1'b0});
         boundary_done = 1'b1;
      end else begin
         next_addr     = '0;
         boundary_done = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         t_p_q        <= 4'd5;
         mc_addr      <= '0;
         mc_b         <= '0;
         first_flag   <= 1'b1;
         int_ack_r    <= 1'b0;
         instr_done_r <= 1'b0;
      end else begin
         t_p_q        <= t_p_d;
         int_ack_r    <= 1'b0;
         instr_done_r <= 1'b0;
         if (addr_edge) begin
            mc_addr      <= next_addr;
            int_ack_r    <= take_int;
            instr_done_r <= boundary_done;
            if (!continuation) first_flag <= 1'b0;
         end
         if (capture_edge) mc_b <= i_mc_rom_data[MCODE_WIDTH-1:0];
      end
   end

   // Pulses are masked while stalled so a hold never stretches them.
   assign o_int_ack    = int_ack_r & ~i_hold;
   assign o_instr_done = instr_done_r & ~i_hold;
   assign o_mc_addr    = mc_addr;
   assign o_mc_b       = mc_b;
   assign o_t_p_q      = t_p_q;
   assign o_t_p_d      = t_p_d;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with a small microcode ROM model whose
// word for the current address is available within the S6 phase.
module tb_mc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_hold;
   logic [7:0]  i_opcode;
   logic        i_opcode_vld;
   logic        i_int_req;
   logic [62:0] i_mc_rom_data;
   logic [8:0]  o_mc_addr;
   logic [53:0] o_mc_b;
   logic [3:0]  o_t_p_d;
   logic [3:0]  o_t_p_q;
   logic        o_int_ack;
   logic        o_instr_done;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   mc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .i_hold        (i_hold),
      .i_opcode      (i_opcode),
      .i_opcode_vld  (i_opcode_vld),
      .i_int_req     (i_int_req),
      .i_mc_rom_data (i_mc_rom_data),
      .o_mc_addr     (o_mc_addr),
      .o_mc_b        (o_mc_b),
      .o_t_p_d       (o_t_p_d),
      .o_t_p_q       (o_t_p_q),
      .o_int_ack     (o_int_ack),
      .o_instr_done  (o_instr_done)
   );

   always #5 clk = ~clk;

   // Control word: bit 53 set only for the MUL chain words 0x148, 0x020, 0x031.
   function automatic logic [53:0] ctrl_of(input logic [8:0] a);
      logic multi;
      multi = (a == 9'h148) || (a == 9'h020) || (a == 9'h031);
      return {multi, a, a, a, a, a[7:0], a};
   endfunction

   function automatic logic [8:0] next_of(input logic [8:0] a);
      case (a)
         9'h148:  return 9'h020;
         9'h020:  return 9'h031;
         9'h031:  return 9'h042;
         default: return a + 9'd1;
      endcase
   endfunction

   assign i_mc_rom_data = {next_of(o_mc_addr), ctrl_of(o_mc_addr)};

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to_s5();
      int n = 0;
      while (o_t_p_q !== 4'd5 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (o_t_p_q !== 4'd5) begin
         $display("FAIL run_to_s5 timeout: phase=%0d required=5", o_t_p_q);
         fails++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; i_hold = 1'b0; i_opcode = 8'h00; i_opcode_vld = 1'b0; i_int_req = 1'b0;
      tick(); tick();
      checks += 5;
      if (o_t_p_q !== 4'd5)    begin $display("FAIL reset_phase: got %0d want 5", o_t_p_q); fails++; end
      if (o_mc_b !== 54'd0)    begin $display("FAIL reset_mc_b: got %h want 0", o_mc_b); fails++; end
      if (o_mc_addr !== 9'd0)  begin $display("FAIL reset_addr: got %h want 0", o_mc_addr); fails++; end
      if (o_int_ack !== 1'b0)  begin $display("FAIL reset_int_ack: got %b want 0", o_int_ack); fails++; end
      if (o_t_p_d !== 4'd6)    begin $display("FAIL reset_t_p_d: got %0d want 6", o_t_p_d); fails++; end
      reset = 1'b0;
   endtask

   task automatic test_power_up();
      logic [3:0] seq [12] = '{4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      int bad = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (o_t_p_q !== seq[k]) bad++;
         if (k == 0) begin
            checks += 2;
            if (o_mc_addr !== 9'h1FE) begin $display("FAIL pu_addr: got %h want 1fe", o_mc_addr); fails++; end
            if (o_instr_done !== 1'b0) begin $display("FAIL pu_first_done: got %b want 0", o_instr_done); fails++; end
         end
         if (k == 1) begin
            checks++;
            if (o_mc_b !== ctrl_of(9'h1FE)) begin $display("FAIL pu_mc_b: got %h want %h", o_mc_b, ctrl_of(9'h1FE)); fails++; end
         end
      end
      checks++;
      if (bad != 0) begin $display("FAIL pu_phase_seq: got %0d wrong phases want 0", bad); fails++; end
   endtask

   task automatic test_single();
      i_opcode = 8'h74; i_opcode_vld = 1'b1;
      tick();
      i_opcode_vld = 1'b0;
      checks += 2;
      if (o_mc_addr !== 9'h0E8)  begin $display("FAIL single_addr: got %h want 0e8", o_mc_addr); fails++; end
      if (o_instr_done !== 1'b1) begin $display("FAIL single_prev_done: got %b want 1", o_instr_done); fails++; end
      tick();
      checks += 2;
      if (o_mc_b !== ctrl_of(9'h0E8)) begin $display("FAIL single_mc_b: got %h want %h", o_mc_b, ctrl_of(9'h0E8)); fails++; end
      if (o_instr_done !== 1'b0)      begin $display("FAIL single_done_width: got %b want 0", o_instr_done); fails++; end
      run_to_s5();
      tick();
      checks += 3;
      if (o_instr_done !== 1'b1)      begin $display("FAIL single_done: got %b want 1", o_instr_done); fails++; end
      if (o_mc_addr !== 9'h000)       begin $display("FAIL single_nop_addr: got %h want 000", o_mc_addr); fails++; end
      if (o_mc_b !== ctrl_of(9'h0E8)) begin $display("FAIL single_mc_b_hold: got %h want %h", o_mc_b, ctrl_of(9'h0E8)); fails++; end
      run_to_s5();
   endtask

   task automatic test_chain();
      logic [8:0] chain [4] = '{9'h148, 9'h020, 9'h031, 9'h042};
      int start;
      i_opcode = 8'hA4; i_opcode_vld = 1'b1;
      tick();
      start = cyc;
      i_opcode_vld = 1'b0;
      checks++;
      if (o_mc_addr !== 9'h148) begin $display("FAIL chain_entry: got %h want 148", o_mc_addr); fails++; end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++;
         if (o_mc_b !== ctrl_of(chain[k-1])) begin $display("FAIL chain_mc_b%0d: got %h want %h", k, o_mc_b, ctrl_of(chain[k-1])); fails++; end
         run_to_s5();
         tick();
         checks += 2;
         if (o_mc_addr !== chain[k]) begin $display("FAIL chain_addr%0d: got %h want %h", k, o_mc_addr, chain[k]); fails++; end
         if (o_instr_done !== 1'b0)  begin $display("FAIL chain_early_done%0d: got %b want 0", k, o_instr_done); fails++; end
      end
      tick();
      run_to_s5();
      tick();
      checks += 2;
      if (o_instr_done !== 1'b1) begin $display("FAIL chain_done: got %b want 1", o_instr_done); fails++; end
      if (cyc - start != 24)     begin $display("FAIL chain_clocks: got %0d want 24", cyc - start); fails++; end
      run_to_s5();
   endtask

   task automatic test_interrupt();
      logic [8:0] chain [3] = '{9'h020, 9'h031, 9'h042};
      i_opcode = 8'hA4; i_opcode_vld = 1'b1;
      tick();
      i_opcode_vld = 1'b0;
      tick(); tick();
      i_int_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_to_s5();
         tick();
         checks += 2;
         if (o_mc_addr !== chain[k]) begin $display("FAIL int_chain_addr%0d: got %h want %h", k, o_mc_addr, chain[k]); fails++; end
         if (o_int_ack !== 1'b0)     begin $display("FAIL int_early_ack%0d: got %b want 0", k, o_int_ack); fails++; end
      end
      run_to_s5();
      i_opcode = 8'h74; i_opcode_vld = 1'b1;
      tick();
      checks += 3;
      if (o_mc_addr !== 9'h1FC)  begin $display("FAIL int_addr: got %h want 1fc", o_mc_addr); fails++; end
      if (o_int_ack !== 1'b1)    begin $display("FAIL int_ack: got %b want 1", o_int_ack); fails++; end
      if (o_instr_done !== 1'b1) begin $display("FAIL int_done: got %b want 1", o_instr_done); fails++; end
      i_int_req = 1'b0; i_opcode_vld = 1'b0;
      tick();
      checks += 2;
      if (o_int_ack !== 1'b0)         begin $display("FAIL int_ack_width: got %b want 0", o_int_ack); fails++; end
      if (o_mc_b !== ctrl_of(9'h1FC)) begin $display("FAIL int_mc_b: got %h want %h", o_mc_b, ctrl_of(9'h1FC)); fails++; end
   endtask

   task automatic test_hold();
      logic [53:0] saved;
      int start = cyc;
      int n = 0;
      tick(); tick();
      saved = o_mc_b;
      i_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks += 3;
         if (o_t_p_q !== 4'd3) begin $display("FAIL hold_phase%0d: got %0d want 3", k, o_t_p_q); fails++; end
         if (o_t_p_d !== 4'd3) begin $display("FAIL hold_t_p_d%0d: got %0d want 3", k, o_t_p_d); fails++; end
         if (o_mc_b !== saved) begin $display("FAIL hold_mc_b%0d: got %h want %h", k, o_mc_b, saved); fails++; end
      end
      i_hold = 1'b0;
      #1;
      checks++;
      if (o_t_p_d !== 4'd4) begin $display("FAIL hold_release_t_p_d: got %0d want 4", o_t_p_d); fails++; end
      while (o_t_p_q !== 4'd1 && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (cyc - start != 9) begin $display("FAIL hold_cycle_len: got %0d want 9", cyc - start); fails++; end
   endtask

   task automatic test_reset_mid();
      run_to_s5();
      i_opcode = 8'hA4; i_opcode_vld = 1'b1;
      tick();
      i_opcode_vld = 1'b0;
      tick(); tick();
      checks++;
      if (o_t_p_q !== 4'd2) begin $display("FAIL rm_phase_pre: got %0d want 2", o_t_p_q); fails++; end
      reset = 1'b1; i_int_req = 1'b1;
      tick();
      reset = 1'b0;
      checks += 3;
      if (o_t_p_q !== 4'd5)   begin $display("FAIL rm_phase: got %0d want 5", o_t_p_q); fails++; end
      if (o_mc_b !== 54'd0)   begin $display("FAIL rm_mc_b: got %h want 0", o_mc_b); fails++; end
      if (o_mc_addr !== 9'd0) begin $display("FAIL rm_addr: got %h want 0", o_mc_addr); fails++; end
      tick();
      checks += 3;
      if (o_mc_addr !== 9'h1FE)  begin $display("FAIL rm_entry: got %h want 1fe", o_mc_addr); fails++; end
      if (o_int_ack !== 1'b0)    begin $display("FAIL rm_int_ack: got %b want 0", o_int_ack); fails++; end
      if (o_instr_done !== 1'b0) begin $display("FAIL rm_done: got %b want 0", o_instr_done); fails++; end
      i_int_req = 1'b0;
      tick();
      checks++;
      if (o_mc_b !== ctrl_of(9'h1FE)) begin $display("FAIL rm_mc_b_entry: got %h want %h", o_mc_b, ctrl_of(9'h1FE)); fails++; end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_single();
      test_chain();
      test_interrupt();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
